// File: rtl/data_mem_if.sv
// data_mem_if: load/store request and response bundle between a CPU data port and the memory responder
// Signals: req_valid/req_ready handshake, req_addr byte address, req_wdata right-aligned store data,
// req_memop funct3 size/sign code, req_we store flag; resp_valid one-cycle pulse, resp_rdata load result,
// resp_err misalignment flag.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_memop;
  logic        req_we;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_addr, req_wdata, req_memop, req_we,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_addr, req_wdata, req_memop, req_we,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data RAM answering one load/store at a time after LATENCY wait cycles
// Ports: clk; rst (asynchronous, active high); bus (data_mem_if.slave) with the request handshake and the
// response pulse. Parameters: ADDR_WIDTH word-index bits, LATENCY wait cycles (1..15).
// Optional: define DMEM_MISALIGN_TRAP_EN to flag misaligned h/w accesses on resp_err with no array write.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input logic       clk,
  input logic       rst,
  data_mem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0]            memop_q, memop_d;
  logic                  we_q, we_d, err_q, err_d;
  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [31:0]           word, ld, wd;
  logic [15:0]           half;
  logic [7:0]            bt;
  logic [3:0]            be;
  logic                  is_b, is_h, access, mis, wr;
  logic                  unused_addr;
  // upper address bits alias away
  assign unused_addr = ^bus.req_addr[31:ADDR_WIDTH+2];
  always_comb begin
    is_b   = memop_q[1:0] == 2'b00;
    is_h   = memop_q[1:0] == 2'b01;
    access = state_q == BUSY && cnt_q == 4'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis    = (is_h && addr_q[0]) || (!is_b && !is_h && addr_q[1:0] != 2'b00);
`else
    mis    = 1'b0;
`endif
    word   = mem[addr_q[ADDR_WIDTH+1:2]];
    bt     = word[{addr_q[1:0], 3'b000} +: 8];
    half   = addr_q[1] ? word[31:16] : word[15:0];
    // memop[2] selects zero extension
    ld     = is_b ? {{24{!memop_q[2] && bt[7]}}, bt} :
             is_h ? {{16{!memop_q[2] && half[15]}}, half} : word;
    be     = is_b ? 4'b0001 << addr_q[1:0] : is_h ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    // replicate right-aligned store data so every enabled lane sees its bytes
    wd     = is_b ? {4{wdata_q[7:0]}} : is_h ? {2{wdata_q[15:0]}} : wdata_q;
    wr     = access && we_q && !mis;
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    memop_d = memop_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_q == IDLE && bus.req_valid) begin
      addr_d  = bus.req_addr[ADDR_WIDTH+1:0];
      wdata_d = bus.req_wdata;
      memop_d = bus.req_memop;
      we_d    = bus.req_we;
      cnt_d   = 4'(LATENCY - 1);
      state_d = BUSY;
    end else if (state_q == BUSY) begin
      cnt_d   = access ? cnt_q : cnt_q - 4'd1;
      state_d = access ? RESP : BUSY;
      rdata_d = access ? ((we_q || mis) ? 32'd0 : ld) : rdata_q;
      err_d   = access ? mis : err_q;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      memop_q <= 3'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      memop_q <= memop_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // array is never reset; wr is gated by state so an early reset suppresses the write
  always_ff @(posedge clk) begin
    if (wr && be[0]) mem[addr_q[ADDR_WIDTH+1:2]][7:0]   <= wd[7:0];
    if (wr && be[1]) mem[addr_q[ADDR_WIDTH+1:2]][15:8]  <= wd[15:8];
    if (wr && be[2]) mem[addr_q[ADDR_WIDTH+1:2]][23:16] <= wd[23:16];
    if (wr && be[3]) mem[addr_q[ADDR_WIDTH+1:2]][31:24] <= wd[31:24];
  end
  assign bus.req_ready  = state_q == IDLE;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and random load/store checks against a byte-array reference model
module tb_data_mem_responder;
  localparam int AW  = 10;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  data_mem_if bus();
  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [7:0]  mm [4096];
  logic [31:0] obs_rdata;
  logic        obs_err, obs_ready;
  int          obs_lat, obs_low;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int msize(input logic [2:0] op);
    return (op == 3'd0 || op == 3'd4) ? 1 : (op == 3'd1 || op == 3'd5) ? 2 : 4;
  endfunction
  function automatic bit model_mis(input logic [31:0] a, input logic [2:0] op);
`ifdef DMEM_MISALIGN_TRAP_EN
    return (int'(a[11:0]) % msize(op)) != 0;
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] op);
    int s = msize(op);
    int base = int'(a[11:0]) - int'(a[11:0]) % s;
    logic [31:0] v = 32'd0;
    for (int i = 0; i < s; i++) v[8*i +: 8] = mm[base + i];
    if ((op == 3'd0 || op == 3'd1) && v[8*s-1] === 1'b1)
      for (int i = s; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction
  task automatic model_store(input logic [31:0] a, input logic [31:0] wdat, input logic [2:0] op);
    int s = msize(op);
    int base = int'(a[11:0]) - int'(a[11:0]) % s;
    for (int i = 0; i < s; i++) mm[base + i] = wdat[8*i +: 8];
  endtask
  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wdat, input logic [2:0] op);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = wdat;
    bus.req_memop = op;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    obs_low = 0;
    obs_lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus.req_ready) obs_low++;
      if (bus.resp_valid) begin
        obs_lat   = k;
        obs_rdata = bus.resp_rdata;
        obs_err   = bus.resp_err;
        break;
      end
    end
    @(negedge clk);
    obs_ready = bus.req_ready;
  endtask
  task automatic run(input logic we, input logic [31:0] a, input logic [31:0] wdat, input logic [2:0] op, input string tag);
    logic        exp_e = model_mis(a, op);
    logic [31:0] exp_d = (we || exp_e) ? 32'd0 : model_load(a, op);
    xact(we, a, wdat, op);
    check({tag, " rdata"}, obs_rdata, exp_d);
    check({tag, " err"}, 32'(obs_err), 32'(exp_e));
    check({tag, " latency"}, 32'(obs_lat), 32'(LAT));
    if (we && !exp_e) model_store(a, wdat, op);
  endtask
  initial begin
    int acc[$];
    int t0;
    logic [31:0] r;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.req_memop = 3'd0;
    #2 rst = 1'b1;
    #1;
    check("reset req_ready", 32'(bus.req_ready), 32'd1);
    check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset resp_rdata", bus.resp_rdata, 32'd0);
    check("reset resp_err", 32'(bus.resp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, "sw 0x10");
    run(1'b0, 32'h10, 32'd0, 3'd2, "lw 0x10");
    check("lw 0x10 value", obs_rdata, 32'hDEADBEEF);
    check("ready low cycles", 32'(obs_low), 32'(LAT + 1));
    check("ready after resp", 32'(obs_ready), 32'd1);
    run(1'b1, 32'h20, 32'd0, 3'd2, "sw 0x20");
    run(1'b1, 32'h22, 32'h80, 3'd0, "sb 0x22");
    run(1'b0, 32'h20, 32'd0, 3'd2, "lw 0x20");
    check("lw 0x20 value", obs_rdata, 32'h00800000);
    run(1'b0, 32'h22, 32'd0, 3'd0, "lb 0x22");
    check("lb 0x22 value", obs_rdata, 32'hFFFFFF80);
    run(1'b0, 32'h22, 32'd0, 3'd4, "lbu 0x22");
    check("lbu 0x22 value", obs_rdata, 32'h00000080);
    run(1'b1, 32'h30, 32'h12348765, 3'd2, "sw 0x30");
    run(1'b0, 32'h30, 32'd0, 3'd1, "lh 0x30");
    check("lh 0x30 value", obs_rdata, 32'hFFFF8765);
    run(1'b0, 32'h32, 32'd0, 3'd5, "lhu 0x32");
    check("lhu 0x32 value", obs_rdata, 32'h00001234);
    run(1'b1, 32'h32, 32'h0000AAAA, 3'd1, "sh 0x32");
    run(1'b0, 32'h30, 32'd0, 3'd2, "lw 0x30");
    check("sh merge value", obs_rdata, 32'hAAAA8765);
    run(1'b1, 32'h1000, 32'h55, 3'd2, "sw 0x1000");
    run(1'b0, 32'h0, 32'd0, 3'd2, "lw 0x0");
    check("alias value", obs_rdata, 32'h55);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_memop = 3'd2;
    t0 = cyc;
    while (acc.size() < 4 && cyc - t0 < 100) begin
      @(negedge clk);
      if (bus.req_ready) acc.push_back(cyc);
    end
    bus.req_valid = 1'b0;
    check("stall accept count", 32'(acc.size()), 32'd4);
    for (int i = 0; i + 1 < acc.size(); i++) check("accept spacing", 32'(acc[i+1] - acc[i]), 32'(LAT + 2));
    repeat (LAT + 4) @(negedge clk);
    run(1'b1, 32'h40, 32'h7, 3'd2, "sw 0x40");
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h40;
    bus.req_wdata = 32'h1;
    bus.req_memop = 3'd2;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid-busy reset ready", 32'(bus.req_ready), 32'd1);
    check("mid-busy reset resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      check("no resp after reset", 32'(bus.resp_valid), 32'd0);
    end
    run(1'b0, 32'h40, 32'd0, 3'd2, "lw 0x40");
    check("dropped store value", obs_rdata, 32'h7);
    run(1'b0, 32'h41, 32'd0, 3'd2, "lw 0x41");
`ifdef DMEM_MISALIGN_TRAP_EN
    check("misaligned lw err", 32'(obs_err), 32'd1);
    check("misaligned lw rdata", obs_rdata, 32'd0);
`else
    check("unaligned lw value", obs_rdata, 32'h7);
    check("unaligned lw err", 32'(obs_err), 32'd0);
`endif
    run(1'b1, 32'h43, 32'h0000BEEF, 3'd1, "sh 0x43");
    run(1'b0, 32'h40, 32'd0, 3'd2, "lw 0x40 after sh");
    for (int w = 0; w < 16; w++) run(1'b1, 32'(w * 4), $urandom, 3'd2, "fill");
    for (int t = 0; t < 60; t++) begin
      r = $urandom;
      run(1'($urandom_range(0, 1)), (r & 32'hFFFFF000) | 32'($urandom_range(0, 63)), $urandom,
          3'($urandom_range(0, 7)), "random");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
